// File: rtl/kmeans_assign_pipe.sv
// kmeans_assign_pipe: streaming nearest-centroid assignment.
// A feature vector is accepted over valid/ready, per-cluster distances are
// accumulated one element per cycle (squared L2 or L1, chosen per vector),
// and the nearest cluster index plus its distance are returned over a
// valid/ready output with backpressure.
// Build option: define KMEANS_HIST_EN to add per-cluster 16-bit membership
// counters on hist_o; otherwise hist_o is tied to 0.
module kmeans_assign_pipe #(
    parameter int DW       = 8,
    parameter int CLUSTERS = 4,
    parameter int PARAMS   = 13,
    localparam int AW      = 2*DW + $clog2(PARAMS+1)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [CLUSTERS*PARAMS*DW-1:0] centroid_i,
    input  logic                          centroid_we_i,
    input  logic                          mode_i,
    input  logic [PARAMS*DW-1:0]          data_i,
    input  logic                          data_valid_i,
    output logic                          data_ready_o,
    output logic [$clog2(CLUSTERS)-1:0]   cluster_o,
    output logic [AW-1:0]                 dist_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [31:0]                   status_o,
    input  logic                          hist_clr_i,
    output logic [CLUSTERS*16-1:0]        hist_o
);

    localparam int CW = $clog2(CLUSTERS);
    localparam int PW = (PARAMS > 1) ? $clog2(PARAMS) : 1;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_ACC  = 4'b0010,
        S_CMP  = 4'b0100,
        S_OUT  = 4'b1000
    } state_e;

    state_e                         state_q, state_d;
    logic [PARAMS*DW-1:0]           data_q, data_d;
    logic                           mode_q, mode_d;
    logic [PW-1:0]                  p_q, p_d;
    logic [CLUSTERS*PARAMS*DW-1:0]  cent_q, cent_d;
    logic [AW-1:0]                  acc_q [CLUSTERS];
    logic [AW-1:0]                  acc_d [CLUSTERS];
    logic [CW-1:0]                  cluster_q, cluster_d;
    logic [AW-1:0]                  dist_q, dist_d;
    logic                           drop_q, drop_d;

    logic                           accept;
    logic                           last_elem;
    logic [DW-1:0]                  x_el, c_el, diff;
    logic [2*DW-1:0]                sq;
    logic [AW-1:0]                  best_dist;
    logic [CW-1:0]                  best_idx;

    assign accept    = data_valid_i && data_ready_o;
    assign last_elem = (p_q == PW'(PARAMS-1));

    // Handshake and status outputs decoded from current state
    always_comb begin
        valid_o      = (state_q == S_OUT);
        data_ready_o = ((state_q == S_IDLE) || ((state_q == S_OUT) && ready_i))
                       && !centroid_we_i;
        cluster_o    = cluster_q;
        dist_o       = dist_q;
        status_o     = {16'h0000, 8'(p_q), 2'b00, mode_q, drop_q, state_q};
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ACC;
            S_ACC:   if (last_elem) state_d = S_CMP;
            S_CMP:   state_d = S_OUT;
            S_OUT: begin
                if (accept)       state_d = S_ACC;
                else if (ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: vector capture, distance accumulation, min scan, centroid load
    always_comb begin
        // NOTE: every comb output and temporary gets a default first so no
        // path leaves it unassigned, which would infer a latch.
        data_d    = data_q;
        mode_d    = mode_q;
        p_d       = p_q;
        cent_d    = cent_q;
        acc_d     = acc_q;
        cluster_d = cluster_q;
        dist_d    = dist_q;
        drop_d    = drop_q;
        x_el      = '0;
        c_el      = '0;
        diff      = '0;
        sq        = '0;
        best_dist = acc_q[0];
        best_idx  = '0;

        if (accept) begin
            data_d = data_i;
            mode_d = mode_i;
            p_d    = '0;
            for (int c = 0; c < CLUSTERS; c++) acc_d[c] = '0;
        end else if (state_q == S_ACC) begin
            x_el = data_q[p_q*DW +: DW];
            for (int c = 0; c < CLUSTERS; c++) begin
                c_el = cent_q[(c*PARAMS + int'(p_q))*DW +: DW];
                diff = (x_el >= c_el) ? (x_el - c_el) : (c_el - x_el);
                sq   = {{DW{1'b0}}, diff} * {{DW{1'b0}}, diff};
                acc_d[c] = acc_q[c] + (mode_q ? AW'(diff) : AW'(sq));
            end
            if (!last_elem) p_d = p_q + 1'b1;
        end

        if (state_q == S_CMP) begin
            // strict less-than keeps the lowest index on ties
            for (int c = 1; c < CLUSTERS; c++) begin
                if (acc_q[c] < best_dist) begin
                    best_dist = acc_q[c];
                    best_idx  = CW'(c);
                end
            end
            cluster_d = best_idx;
            dist_d    = best_dist;
        end

        // writes during a computation would corrupt the vector in flight
        if (centroid_we_i) begin
            if ((state_q == S_ACC) || (state_q == S_CMP)) drop_d = 1'b1;
            else                                          cent_d = centroid_i;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (reset_i) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            mode_q    <= 1'b0;
            p_q       <= '0;
            // NOTE: the centroid bank is a register array that must read as
            // zero after reset, so it is reset explicitly rather than left
            // undefined like a RAM.
            cent_q    <= '0;
            for (int c = 0; c < CLUSTERS; c++) acc_q[c] <= '0;
            cluster_q <= '0;
            dist_q    <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            mode_q    <= mode_d;
            p_q       <= p_d;
            cent_q    <= cent_d;
            acc_q     <= acc_d;
            cluster_q <= cluster_d;
            dist_q    <= dist_d;
            drop_q    <= drop_d;
        end
    end

`ifdef KMEANS_HIST_EN
    logic [15:0] hist_q [CLUSTERS];
    logic [15:0] hist_d [CLUSTERS];

    // Saturating membership count per output handshake; clear has priority
    always_comb begin
        hist_d = hist_q;
        if (hist_clr_i) begin
            for (int c = 0; c < CLUSTERS; c++) hist_d[c] = '0;
        end else if (valid_o && ready_i && (hist_q[cluster_q] != 16'hFFFF)) begin
            hist_d[cluster_q] = hist_q[cluster_q] + 16'd1;
        end
    end

    // Histogram registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int c = 0; c < CLUSTERS; c++) hist_q[c] <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    // Pack counters onto the flat output bus
    always_comb begin
        hist_o = '0;
        for (int c = 0; c < CLUSTERS; c++) hist_o[c*16 +: 16] = hist_q[c];
    end
`else
    logic unused_hist_clr;
    assign unused_hist_clr = hist_clr_i;
    assign hist_o          = '0;
`endif

endmodule

// File: tb/tb_kmeans_assign_pipe.sv
// Directed bench for kmeans_assign_pipe with hand-computed distances.
// Centroids c0..c3 are constant vectors; each test vector is constant too,
// so every distance is PARAMS * (per-element term).
module tb_kmeans_assign_pipe;

    localparam int DW = 8;
    localparam int CL = 4;
    localparam int PR = 13;
    localparam int AW = 2*DW + $clog2(PR+1);

    logic                    clk_i = 1'b0;
    logic                    reset_i;
    logic [CL*PR*DW-1:0]     centroid_i;
    logic                    centroid_we_i;
    logic                    mode_i;
    logic [PR*DW-1:0]        data_i;
    logic                    data_valid_i;
    logic                    data_ready_o;
    logic [$clog2(CL)-1:0]   cluster_o;
    logic [AW-1:0]           dist_o;
    logic                    valid_o;
    logic                    ready_i;
    logic [31:0]             status_o;
    logic                    hist_clr_i;
    logic [CL*16-1:0]        hist_o;

    int n_checks = 0;
    int n_fail   = 0;

    kmeans_assign_pipe #(.DW(DW), .CLUSTERS(CL), .PARAMS(PR)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .centroid_i(centroid_i), .centroid_we_i(centroid_we_i),
        .mode_i(mode_i), .data_i(data_i), .data_valid_i(data_valid_i),
        .data_ready_o(data_ready_o), .cluster_o(cluster_o), .dist_o(dist_o),
        .valid_o(valid_o), .ready_i(ready_i), .status_o(status_o),
        .hist_clr_i(hist_clr_i), .hist_o(hist_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CL*PR*DW-1:0] bank(input logic [7:0] v0, input logic [7:0] v1,
                                                 input logic [7:0] v2, input logic [7:0] v3);
        logic [7:0] v [CL];
        logic [CL*PR*DW-1:0] b;
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        b = '0;
        for (int c = 0; c < CL; c++)
            for (int p = 0; p < PR; p++)
                b[(c*PR + p)*DW +: DW] = v[c];
        return b;
    endfunction

    task automatic load_centroids(input logic [CL*PR*DW-1:0] b);
        centroid_i    = b;
        centroid_we_i = 1'b1;
        @(posedge clk_i); #1;
        centroid_we_i = 1'b0;
    endtask

    // Present a vector while the DUT is idle; returns one cycle after the accept edge
    task automatic start_vec(input logic [7:0] x, input logic m);
        data_i       = {PR{x}};
        mode_i       = m;
        data_valid_i = 1'b1;
        @(posedge clk_i); #1;
        data_valid_i = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int cyc);
        cyc = 0;
        while (!valid_o && cyc < 100) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        if (!valid_o) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic finish_vec();
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [7:0] x, input logic m,
                           input int exp_c, input int exp_d);
        int cyc;
        start_vec(x, m);
        wait_valid(tag, cyc);
        check({tag, "_lat"}, 32'(cyc), 32'd14);
        check({tag, "_cluster"}, 32'(cluster_o), 32'(exp_c));
        check({tag, "_dist"}, 32'(dist_o), 32'(exp_d));
        finish_vec();
    endtask

    initial begin
        int cyc;
        int rises;
        logic [15:0] exp_h [CL];

        reset_i = 1'b1; centroid_i = '0; centroid_we_i = 1'b0; mode_i = 1'b0;
        data_i = '0; data_valid_i = 1'b0; ready_i = 1'b0; hist_clr_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;

        // Reset state
        check("rst_status", status_o, 32'h0000_0001);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_ready", 32'(data_ready_o), 32'd1);
        check("rst_cluster", 32'(cluster_o), 32'd0);
        check("rst_dist", 32'(dist_o), 32'd0);
        check("rst_hist", hist_o[31:0] | hist_o[63:32], 32'd0);

        // centroid_we blocks data_ready in IDLE
        centroid_i = bank(8'd0, 8'd10, 8'd20, 8'd255);
        centroid_we_i = 1'b1;
        #1 check("we_blocks_ready", 32'(data_ready_o), 32'd0);
        @(posedge clk_i); #1;
        centroid_we_i = 1'b0;

        // L2 / L1 / ties
        run_vec("l2_12", 8'd12, 1'b0, 1, 52);
        run_vec("l1_12", 8'd12, 1'b1, 1, 26);
        run_vec("l1_tie15", 8'd15, 1'b1, 1, 65);
        run_vec("l2_tie5", 8'd5, 1'b0, 0, 325);
        run_vec("l2_255", 8'd255, 1'b0, 3, 0);

        // Worst-case accumulation: all centroids 0, all data 255 -> 13*255^2
        load_centroids(bank(8'd0, 8'd0, 8'd0, 8'd0));
        run_vec("ovf", 8'd255, 1'b0, 0, 845325);

        // Backpressure then back-to-back accept
        load_centroids(bank(8'd0, 8'd10, 8'd20, 8'd255));
        start_vec(8'd12, 1'b0);
        wait_valid("bp", cyc);
        data_i = {PR{8'd15}}; mode_i = 1'b1; data_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!valid_o || cluster_o != 2'd1 || dist_o != 20'd52 || data_ready_o)
                check($sformatf("bp_hold_%0d", i),
                      {valid_o, data_ready_o, 8'(cluster_o), 20'(dist_o)},
                      {1'b1, 1'b0, 8'd1, 20'd52});
            else
                check($sformatf("bp_hold_%0d", i), 32'(dist_o), 32'd52);
            @(posedge clk_i);
        end
        #1;
        check("bp_status", status_o, 32'h0000_0C08);
        ready_i = 1'b1;
        #1 check("b2b_ready", 32'(data_ready_o), 32'd1);
        @(posedge clk_i); #1;
        ready_i = 1'b0; data_valid_i = 1'b0;
        check("b2b_valid_low", 32'(valid_o), 32'd0);
        check("b2b_state_acc", status_o, 32'h0000_0022);
        wait_valid("b2b", cyc);
        check("b2b_lat", 32'(cyc), 32'd14);
        check("b2b_cluster", 32'(cluster_o), 32'd1);
        check("b2b_dist", 32'(dist_o), 32'd65);
        finish_vec();

        // Centroid write during ACC is dropped
        start_vec(8'd12, 1'b0);
        centroid_i = bank(8'd12, 8'd12, 8'd12, 8'd12);
        centroid_we_i = 1'b1;
        @(posedge clk_i); #1;
        centroid_we_i = 1'b0;
        wait_valid("drop", cyc);
        check("drop_cluster", 32'(cluster_o), 32'd1);
        check("drop_dist", 32'(dist_o), 32'd52);
        check("drop_status", status_o, 32'h0000_0C18);
        finish_vec();
        run_vec("drop_bank_kept", 8'd12, 1'b1, 1, 26);

        // Reset mid-ACC aborts the vector
        start_vec(8'd12, 1'b0);
        repeat (4) @(posedge clk_i);
        #1 reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        check("midrst_status", status_o, 32'h0000_0001);
        rises = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid_o) rises++;
            @(posedge clk_i); #1;
        end
        check("midrst_no_valid", 32'(rises), 32'd0);

        // Histogram: three vectors to c1, one to c2, then clear
        load_centroids(bank(8'd0, 8'd10, 8'd20, 8'd255));
        run_vec("h1a", 8'd12, 1'b0, 1, 52);
        run_vec("h1b", 8'd11, 1'b1, 1, 13);
        run_vec("h1c", 8'd9, 1'b1, 1, 13);
        run_vec("h2", 8'd21, 1'b1, 2, 13);
`ifdef KMEANS_HIST_EN
        exp_h[0] = 16'd0; exp_h[1] = 16'd3; exp_h[2] = 16'd1; exp_h[3] = 16'd0;
`else
        for (int c = 0; c < CL; c++) exp_h[c] = 16'd0;
`endif
        for (int c = 0; c < CL; c++)
            check($sformatf("hist_%0d", c), 32'(hist_o[c*16 +: 16]), 32'(exp_h[c]));
        hist_clr_i = 1'b1;
        @(posedge clk_i); #1;
        hist_clr_i = 1'b0;
        for (int c = 0; c < CL; c++)
            check($sformatf("hist_clr_%0d", c), 32'(hist_o[c*16 +: 16]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
